// File: rtl/inst_queue.sv
// Fetch-to-decode instruction queue: compacts up to 4 enabled lanes per
// group into a circular buffer and presents the 2 oldest entries to decode.
module inst_queue #(
   parameter int DEPTH = 16,
   parameter int PTR_W = 4
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               flush_w_i,
   input  logic               SCT_valid_i,
   input  logic [31:0]        SCT_VAddr_i,
   input  logic [3:0]         SCT_originEnable_i,
   input  logic [127:0]       inst_rdata_i,
   input  logic               SCT_hasException_i,
   input  logic [4:0]         SCT_ExcCode_i,
   input  logic               SCT_isRefill_i,
   output logic               IQ_allowin_o,
   output logic [1:0]         IQ_valid_o,
   output logic [63:0]        IQ_inst_o,
   output logic [63:0]        IQ_VAddr_o,
   output logic [1:0]         IQ_hasException_o,
   output logic [9:0]         IQ_ExcCode_o,
   output logic [1:0]         IQ_isRefill_o,
   input  logic [1:0]         ID_accept_i,
   output logic [PTR_W:0]     IQ_count_o
);

   typedef logic [PTR_W-1:0] ptr_t;
   typedef logic [PTR_W:0]   cnt_t;

   localparam cnt_t LP_LIM = cnt_t'(DEPTH - 4);

   ptr_t        r_head, r_tail;
   cnt_t        r_count;
   logic [31:0] r_vaddr  [DEPTH];
   logic [31:0] r_inst   [DEPTH];
   logic        r_exc    [DEPTH];
   logic [4:0]  r_code   [DEPTH];
   logic        r_refill [DEPTH];

   logic        w_enq;
   logic [2:0]  w_nenq;
   logic [1:0]  w_ndeq;
   logic [1:0]  w_low;
   logic        w_we    [4];
   ptr_t        w_widx  [4];
   logic [31:0] w_wpc   [4];
   logic [31:0] w_winst [4];
   ptr_t        w_h1;

   assign IQ_allowin_o = (r_count <= LP_LIM);
   assign w_enq = SCT_valid_i && IQ_allowin_o && !flush_w_i;

   always_comb begin
      w_low = 2'd0;
      if (SCT_originEnable_i[0])      w_low = 2'd0;
      else if (SCT_originEnable_i[1]) w_low = 2'd1;
      else if (SCT_originEnable_i[2]) w_low = 2'd2;
      else if (SCT_originEnable_i[3]) w_low = 2'd3;
   end

   // Lane k lands at tail + (number of enabled lanes below k)
   always_comb begin
      logic [2:0] v_acc;
      v_acc = 3'd0;
      for (int k = 0; k < 4; k++) begin
         w_we[k]    = w_enq && SCT_originEnable_i[k]
                      && !SCT_hasException_i;
         w_widx[k]  = r_tail + ptr_t'(v_acc);
         w_wpc[k]   = SCT_VAddr_i + {28'd0, 2'(k), 2'b00};
         w_winst[k] = inst_rdata_i[32*k +: 32];
         v_acc      = v_acc + {2'b00, SCT_originEnable_i[k]};
      end
      if (SCT_hasException_i) begin
         w_we[0]    = w_enq;
         w_widx[0]  = r_tail;
         w_wpc[0]   = SCT_VAddr_i + {28'd0, w_low, 2'b00};
         w_winst[0] = 32'h0;
      end
      if (!w_enq)                  w_nenq = 3'd0;
      else if (SCT_hasException_i) w_nenq = 3'd1;
      else                         w_nenq = v_acc;
   end

   always_comb begin
      w_ndeq = 2'd0;
      case (ID_accept_i)
         2'b11:   w_ndeq = IQ_valid_o[1] ? 2'd2 :
                           (IQ_valid_o[0] ? 2'd1 : 2'd0);
         2'b01:   w_ndeq = IQ_valid_o[0] ? 2'd1 : 2'd0;
         default: w_ndeq = 2'd0;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_head  <= '0;
         r_tail  <= '0;
         r_count <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            r_vaddr[i]  <= '0;
            r_inst[i]   <= '0;
            r_exc[i]    <= 1'b0;
            r_code[i]   <= '0;
            r_refill[i] <= 1'b0;
         end
      end else if (flush_w_i) begin
         r_head  <= '0;
         r_tail  <= '0;
         r_count <= '0;
      end else begin
         for (int k = 0; k < 4; k++) begin
            if (w_we[k]) begin
               r_vaddr[w_widx[k]]  <= w_wpc[k];
               r_inst[w_widx[k]]   <= w_winst[k];
               r_exc[w_widx[k]]    <= SCT_hasException_i;
               r_code[w_widx[k]]   <= SCT_hasException_i ?
                                      SCT_ExcCode_i : 5'd0;
               r_refill[w_widx[k]] <= SCT_hasException_i &&
                                      SCT_isRefill_i;
            end
         end
         r_head  <= r_head + ptr_t'(w_ndeq);
         r_tail  <= r_tail + ptr_t'(w_nenq);
         r_count <= r_count + cnt_t'(w_nenq) - cnt_t'(w_ndeq);
      end
   end

   assign w_h1 = r_head + ptr_t'(1);

   assign IQ_count_o        = r_count;
   assign IQ_valid_o        = {r_count >= cnt_t'(2),
                               r_count >= cnt_t'(1)};
   assign IQ_inst_o         = {r_inst[w_h1], r_inst[r_head]};
   assign IQ_VAddr_o        = {r_vaddr[w_h1], r_vaddr[r_head]};
   assign IQ_hasException_o = {r_exc[w_h1], r_exc[r_head]};
   assign IQ_ExcCode_o      = {r_code[w_h1], r_code[r_head]};
   assign IQ_isRefill_o     = {r_refill[w_h1], r_refill[r_head]};

endmodule

// File: tb/tb_inst_queue.sv
// Directed bench for inst_queue: compaction, exceptions, backpressure,
// wrap, flush collision and asynchronous reset.
module tb_inst_queue;

   logic         clk = 1'b0;
   logic         rst;
   logic         flush_w_i;
   logic         SCT_valid_i;
   logic [31:0]  SCT_VAddr_i;
   logic [3:0]   SCT_originEnable_i;
   logic [127:0] inst_rdata_i;
   logic         SCT_hasException_i;
   logic [4:0]   SCT_ExcCode_i;
   logic         SCT_isRefill_i;
   logic         IQ_allowin_o;
   logic [1:0]   IQ_valid_o;
   logic [63:0]  IQ_inst_o;
   logic [63:0]  IQ_VAddr_o;
   logic [1:0]   IQ_hasException_o;
   logic [9:0]   IQ_ExcCode_o;
   logic [1:0]   IQ_isRefill_o;
   logic [1:0]   ID_accept_i;
   logic [4:0]   IQ_count_o;

   int n_vec = 0;
   int n_err = 0;

   inst_queue #(.DEPTH(16), .PTR_W(4)) dut (
      .clk                (clk),
      .rst                (rst),
      .flush_w_i          (flush_w_i),
      .SCT_valid_i        (SCT_valid_i),
      .SCT_VAddr_i        (SCT_VAddr_i),
      .SCT_originEnable_i (SCT_originEnable_i),
      .inst_rdata_i       (inst_rdata_i),
      .SCT_hasException_i (SCT_hasException_i),
      .SCT_ExcCode_i      (SCT_ExcCode_i),
      .SCT_isRefill_i     (SCT_isRefill_i),
      .IQ_allowin_o       (IQ_allowin_o),
      .IQ_valid_o         (IQ_valid_o),
      .IQ_inst_o          (IQ_inst_o),
      .IQ_VAddr_o         (IQ_VAddr_o),
      .IQ_hasException_o  (IQ_hasException_o),
      .IQ_ExcCode_o       (IQ_ExcCode_o),
      .IQ_isRefill_o      (IQ_isRefill_o),
      .ID_accept_i        (ID_accept_i),
      .IQ_count_o         (IQ_count_o)
   );

   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag,
                      input logic [127:0] obs,
                      input logic [127:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic grp(input logic [31:0] va, input logic [3:0] m,
                      input logic [127:0] d);
      SCT_valid_i        = 1'b1;
      SCT_VAddr_i        = va;
      SCT_originEnable_i = m;
      inst_rdata_i       = d;
      step();
      SCT_valid_i        = 1'b0;
   endtask

   task automatic acc(input logic [1:0] a);
      ID_accept_i = a;
      step();
      ID_accept_i = 2'b00;
   endtask

   initial begin
      rst = 1'b0;
      flush_w_i = 1'b0;
      SCT_valid_i = 1'b0;
      SCT_VAddr_i = '0;
      SCT_originEnable_i = '0;
      inst_rdata_i = '0;
      SCT_hasException_i = 1'b0;
      SCT_ExcCode_i = '0;
      SCT_isRefill_i = 1'b0;
      ID_accept_i = 2'b00;
      #12;
      chk("rst_valid", IQ_valid_o, 2'b00);
      chk("rst_count", IQ_count_o, 5'd0);
      chk("rst_allowin", IQ_allowin_o, 1'b1);
      chk("rst_inst", IQ_inst_o, 64'h0);
      step();
      rst = 1'b1;
      step();

      // compaction
      grp(32'hBFC00010, 4'b1010,
          {32'hA3A3A3A3, 32'hA2A2A2A2, 32'hA1A1A1A1, 32'hA0A0A0A0});
      chk("cmp_count", IQ_count_o, 5'd2);
      chk("cmp_valid", IQ_valid_o, 2'b11);
      chk("cmp_pc", IQ_VAddr_o, {32'hBFC0001C, 32'hBFC00014});
      chk("cmp_inst", IQ_inst_o, {32'hA3A3A3A3, 32'hA1A1A1A1});
      chk("cmp_exc", IQ_hasException_o, 2'b00);
      acc(2'b11);
      chk("deq2_count", IQ_count_o, 5'd0);
      chk("deq2_valid", IQ_valid_o, 2'b00);

      // exception group
      SCT_hasException_i = 1'b1;
      SCT_ExcCode_i = 5'h02;
      SCT_isRefill_i = 1'b1;
      grp(32'h00400000, 4'b1100, {4{32'hDEADBEEF}});
      SCT_hasException_i = 1'b0;
      SCT_ExcCode_i = 5'h00;
      SCT_isRefill_i = 1'b0;
      chk("exc_count", IQ_count_o, 5'd1);
      chk("exc_valid", IQ_valid_o, 2'b01);
      chk("exc_pc", IQ_VAddr_o[31:0], 32'h00400008);
      chk("exc_inst", IQ_inst_o[31:0], 32'h0);
      chk("exc_flag", IQ_hasException_o[0], 1'b1);
      chk("exc_code", IQ_ExcCode_o[4:0], 5'h02);
      chk("exc_refill", IQ_isRefill_o[0], 1'b1);
      acc(2'b10);
      chk("acc10_ignored", IQ_count_o, 5'd1);
      acc(2'b11);
      chk("acc11_masked", IQ_count_o, 5'd0);

      // fill and backpressure
      grp(32'h00001000, 4'b1111, '0);
      grp(32'h00001010, 4'b1111, '0);
      grp(32'h00001020, 4'b1111, '0);
      chk("c12_count", IQ_count_o, 5'd12);
      chk("c12_allowin", IQ_allowin_o, 1'b1);
      grp(32'h00001030, 4'b0111, '0);
      chk("c15_count", IQ_count_o, 5'd15);
      chk("c15_allowin", IQ_allowin_o, 1'b0);
      grp(32'h00009000, 4'b1111, '0);
      chk("held_count", IQ_count_o, 5'd15);
      SCT_valid_i = 1'b1;
      SCT_VAddr_i = 32'h00009000;
      acc(2'b11);
      SCT_valid_i = 1'b0;
      chk("c13_count", IQ_count_o, 5'd13);
      chk("c13_allowin", IQ_allowin_o, 1'b0);
      chk("c13_pc", IQ_VAddr_o, {32'h0000100C, 32'h00001008});
      acc(2'b01);
      chk("c12b_allowin", IQ_allowin_o, 1'b1);
      grp(32'h00001040, 4'b1111, '0);
      chk("full_count", IQ_count_o, 5'd16);
      chk("full_allowin", IQ_allowin_o, 1'b0);
      chk("full_pc", IQ_VAddr_o, {32'h00001010, 32'h0000100C});

      // flush collision
      acc(2'b11);
      acc(2'b11);
      acc(2'b11);
      acc(2'b01);
      chk("c9_count", IQ_count_o, 5'd9);
      chk("c9_pc", IQ_VAddr_o[31:0], 32'h00001028);
      flush_w_i = 1'b1;
      ID_accept_i = 2'b11;
      grp(32'h00002000, 4'b1111, {4{32'h22222222}});
      flush_w_i = 1'b0;
      ID_accept_i = 2'b00;
      chk("fl_count", IQ_count_o, 5'd0);
      chk("fl_valid", IQ_valid_o, 2'b00);
      chk("fl_allowin", IQ_allowin_o, 1'b1);
      chk("fl_storage", IQ_VAddr_o, {32'h00001038, 32'h00001034});
      grp(32'h00003000, 4'b0001, {4{32'h33333333}});
      chk("fl_tail0", IQ_VAddr_o[31:0], 32'h00003000);
      acc(2'b01);

      // advance pointers to 14
      grp(32'h00004000, 4'b1111, '0);
      grp(32'h00004010, 4'b1111, '0);
      grp(32'h00004020, 4'b1111, '0);
      grp(32'h00004030, 4'b0001, '0);
      chk("adv_count", IQ_count_o, 5'd13);
      for (int i = 0; i < 6; i++) acc(2'b11);
      acc(2'b01);
      chk("adv_empty", IQ_count_o, 5'd0);

      // wrap
      grp(32'h00005000, 4'b1111,
          {32'hB3B3B3B3, 32'hB2B2B2B2, 32'hB1B1B1B1, 32'hB0B0B0B0});
      chk("wr_count", IQ_count_o, 5'd4);
      chk("wr_pc", IQ_VAddr_o, {32'h00005004, 32'h00005000});
      SCT_hasException_i = 1'b0;
      ID_accept_i = 2'b01;
      grp(32'h00005010, 4'b1111, '0);
      ID_accept_i = 2'b00;
      chk("wr_sim_count", IQ_count_o, 5'd7);
      chk("wr_sim_pc", IQ_VAddr_o, {32'h00005008, 32'h00005004});
      chk("wr_sim_inst", IQ_inst_o, {32'hB2B2B2B2, 32'hB1B1B1B1});

      // async reset mid-traffic
      rst = 1'b0;
      #1;
      chk("arst_valid", IQ_valid_o, 2'b00);
      chk("arst_count", IQ_count_o, 5'd0);
      chk("arst_allowin", IQ_allowin_o, 1'b1);
      chk("arst_inst", IQ_inst_o, 64'h0);
      chk("arst_pc", IQ_VAddr_o, 64'h0);
      step();
      rst = 1'b1;
      step();

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
